// File: rtl/rv32imf_fp_issue_tracker.sv
// FP issue tracker: gates core FP requests into the FPU, tracks destination registers in order
// and registers each FPU result with its waddr for writeback, accumulating sticky fflags.
module rv32imf_fp_issue_tracker #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [2:0][31:0] operands_i,
    input  logic [5:0]       op_i,
    input  logic [14:0]      flags_i,
    input  logic [4:0]       waddr_i,
    output logic             apu_req_o,
    input  logic             apu_gnt_i,
    output logic [2:0][31:0] apu_operands_o,
    output logic [5:0]       apu_op_o,
    output logic [14:0]      apu_flags_o,
    input  logic             apu_rvalid_i,
    input  logic [31:0]      apu_rdata_i,
    input  logic [4:0]       apu_rflags_i,
    output logic             result_valid_o,
    output logic [31:0]      result_data_o,
    output logic [4:0]       result_waddr_o,
    output logic [4:0]       result_flags_o,
    input  logic             fflags_clr_i,
    output logic [4:0]       fflags_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [4:0]    fifo_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          div_pend_q, div_pend_d;
    logic          err_q, err_d;
    logic          result_valid_q, result_valid_d;
    logic [31:0]   result_data_q, result_data_d;
    logic [4:0]    result_waddr_q, result_waddr_d;
    logic [4:0]    result_flags_q, result_flags_d;
    logic [4:0]    fflags_q, fflags_d;

    logic is_ds, empty, issue_ok, pop_fifo, bypass, pop, push;

    assign is_ds    = (op_i[3:0] == 4'd4) || (op_i[3:0] == 4'd5);
    assign empty    = (count_q == '0);
    assign issue_ok = (count_q < DEPTH_C) && !div_pend_q && (!is_ds || empty);

    assign apu_req_o      = req_i & issue_ok;
    assign gnt_o          = apu_req_o & apu_gnt_i;
    assign apu_operands_o = operands_i;
    assign apu_op_o       = op_i;
    assign apu_flags_o    = flags_i;

    // A result arriving while empty can only belong to an op granted this same cycle
    assign pop_fifo = apu_rvalid_i & !empty;
    assign bypass   = apu_rvalid_i & empty & gnt_o;
    assign pop      = pop_fifo | bypass;
    assign push     = gnt_o & !bypass;

    always_comb begin
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        count_d        = count_q;
        div_pend_d     = div_pend_q;
        err_d          = err_q;
        result_valid_d = pop;
        result_data_d  = result_data_q;
        result_waddr_d = result_waddr_q;
        result_flags_d = result_flags_q;
        fflags_d       = (fflags_clr_i ? 5'd0 : fflags_q) | (pop ? apu_rflags_i : 5'd0);

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_fifo) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop_fifo})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push && is_ds) begin
            div_pend_d = 1'b1;
        end else if (pop) begin
            div_pend_d = 1'b0;
        end

        if (apu_rvalid_i && empty && !gnt_o) begin
            err_d = 1'b1;
        end

        if (pop) begin
            result_data_d  = apu_rdata_i;
            result_waddr_d = bypass ? waddr_i : fifo_q[rptr_q];
            result_flags_d = apu_rflags_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= 5'd0;
            end
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            div_pend_q     <= 1'b0;
            err_q          <= 1'b0;
            result_valid_q <= 1'b0;
            result_data_q  <= 32'd0;
            result_waddr_q <= 5'd0;
            result_flags_q <= 5'd0;
            fflags_q       <= 5'd0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= waddr_i;
            end
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            div_pend_q     <= div_pend_d;
            err_q          <= err_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            result_waddr_q <= result_waddr_d;
            result_flags_q <= result_flags_d;
            fflags_q       <= fflags_d;
        end
    end

    assign result_valid_o = result_valid_q;
    assign result_data_o  = result_data_q;
    assign result_waddr_o = result_waddr_q;
    assign result_flags_o = result_flags_q;
    assign fflags_o       = fflags_q;
    assign err_o          = err_q;
    assign busy_o         = (count_q != '0) | result_valid_q;

endmodule

// File: tb/tb_rv32imf_fp_issue_tracker.sv
// Self-checking bench for rv32imf_fp_issue_tracker: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the issue/return rules.
module tb_rv32imf_fp_issue_tracker;

    localparam int DEPTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             req_i;
    logic             gnt_o;
    logic [2:0][31:0] operands_i;
    logic [5:0]       op_i;
    logic [14:0]      flags_i;
    logic [4:0]       waddr_i;
    logic             apu_req_o;
    logic             apu_gnt_i;
    logic [2:0][31:0] apu_operands_o;
    logic [5:0]       apu_op_o;
    logic [14:0]      apu_flags_o;
    logic             apu_rvalid_i;
    logic [31:0]      apu_rdata_i;
    logic [4:0]       apu_rflags_i;
    logic             result_valid_o;
    logic [31:0]      result_data_o;
    logic [4:0]       result_waddr_o;
    logic [4:0]       result_flags_o;
    logic             fflags_clr_i;
    logic [4:0]       fflags_o;
    logic             busy_o;
    logic             err_o;

    rv32imf_fp_issue_tracker #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .operands_i(operands_i), .op_i(op_i), .flags_i(flags_i), .waddr_i(waddr_i),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_operands_o(apu_operands_o),
        .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o), .apu_rvalid_i(apu_rvalid_i),
        .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
        .result_valid_o(result_valid_o), .result_data_o(result_data_o),
        .result_waddr_o(result_waddr_o), .result_flags_o(result_flags_o),
        .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: the queue holds waddrs of ops the FPU still owes us
    logic [4:0]  modelQ[$];
    logic        modelDiv, modelErr, modelRv;
    logic [31:0] modelData;
    logic [4:0]  modelWaddr, modelFlags, modelFf;
    logic        expReq, expGnt, expBusy;

    function automatic void modelClear();
        modelQ.delete();
        modelDiv = 0; modelErr = 0; modelRv = 0;
        modelData = 0; modelWaddr = 0; modelFlags = 0; modelFf = 0;
    endfunction

    // Drives one cycle of inputs shortly after a rising edge, then predicts the comb outputs
    task automatic applyStimulus(input logic req, input logic [5:0] op, input logic [4:0] waddr,
                                 input logic agnt, input logic rvalid, input logic [31:0] rdata,
                                 input logic [4:0] rflags, input logic clr);
        logic isDs;
        logic ok;
        req_i = req; op_i = op; waddr_i = waddr; apu_gnt_i = agnt;
        apu_rvalid_i = rvalid; apu_rdata_i = rdata; apu_rflags_i = rflags; fflags_clr_i = clr;
        operands_i = {$urandom, $urandom, $urandom};
        flags_i = 15'($urandom);
        #1;
        isDs    = (op[3:0] == 4'd4) || (op[3:0] == 4'd5);
        ok      = (modelQ.size() < DEPTH) && !modelDiv && (!isDs || modelQ.size() == 0);
        expReq  = req && ok;
        expGnt  = expReq && agnt;
        expBusy = (modelQ.size() != 0) || modelRv;
    endtask

    // Advances the model across a rising edge using the inputs currently applied
    task automatic clockEdge();
        logic isDs, popped, bypass;
        logic [4:0] w;
        @(posedge clk_i);
        isDs   = (op_i[3:0] == 4'd4) || (op_i[3:0] == 4'd5);
        popped = 0;
        bypass = 0;
        w      = 0;
        if (apu_rvalid_i) begin
            if (modelQ.size() != 0) begin
                w = modelQ.pop_front();
                popped = 1;
                modelDiv = 0;
            end else if (expGnt) begin
                w = waddr_i;
                popped = 1;
                bypass = 1;
            end else begin
                modelErr = 1;
            end
        end
        if (expGnt && !bypass) begin
            modelQ.push_back(waddr_i);
            if (isDs) modelDiv = 1;
        end
        modelFf = (fflags_clr_i ? 5'd0 : modelFf) | (popped ? apu_rflags_i : 5'd0);
        modelRv = popped;
        if (popped) begin
            modelData = apu_rdata_i; modelWaddr = w; modelFlags = apu_rflags_i;
        end
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 6'd0, 5'd0, 0, 0, 32'd0, 5'd0, 0);
    endtask

    task automatic test_reset();
        rst_ni = 0;
        idle();
        modelClear();
        repeat (2) @(posedge clk_i);
        #1;
        nChecks++; if (result_valid_o !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_rv: got %0b want 0", result_valid_o); end
        nChecks++; if (result_data_o !== 32'd0) begin nErrors++; $display("[TB] FAIL reset_data: got %0h want 0", result_data_o); end
        nChecks++; if (result_waddr_o !== 5'd0) begin nErrors++; $display("[TB] FAIL reset_waddr: got %0d want 0", result_waddr_o); end
        nChecks++; if (fflags_o !== 5'd0) begin nErrors++; $display("[TB] FAIL reset_fflags: got %0b want 0", fflags_o); end
        nChecks++; if ({busy_o, err_o, gnt_o, apu_req_o} !== 4'b0) begin nErrors++; $display("[TB] FAIL reset_misc: got %4b want 0000", {busy_o, err_o, gnt_o, apu_req_o}); end
        rst_ni = 1;
    endtask

    task automatic test_comb_fpu();
        applyStimulus(1, 6'd0, 5'd5, 1, 1, 32'h40400000, 5'd0, 0);
        nChecks++; if (gnt_o !== 1'b1) begin nErrors++; $display("[TB] FAIL comb_gnt: got %0b want 1", gnt_o); end
        clockEdge();
        nChecks++; if (result_valid_o !== 1'b1) begin nErrors++; $display("[TB] FAIL comb_rv: got %0b want 1", result_valid_o); end
        nChecks++; if (result_waddr_o !== 5'd5) begin nErrors++; $display("[TB] FAIL comb_waddr: got %0d want 5", result_waddr_o); end
        nChecks++; if (result_data_o !== 32'h40400000) begin nErrors++; $display("[TB] FAIL comb_data: got %0h want 40400000", result_data_o); end
        nChecks++; if (err_o !== 1'b0) begin nErrors++; $display("[TB] FAIL comb_err: got %0b want 0", err_o); end
        idle();
        clockEdge();
        nChecks++; if ({result_valid_o, busy_o} !== 2'b00) begin nErrors++; $display("[TB] FAIL comb_drain: got %2b want 00 (count must stay 0)", {result_valid_o, busy_o}); end
    endtask

    task automatic test_div_order();
        applyStimulus(1, 6'd4, 5'd3, 1, 0, 32'd0, 5'd0, 0);
        nChecks++; if (gnt_o !== 1'b1) begin nErrors++; $display("[TB] FAIL div_gnt: got %0b want 1", gnt_o); end
        clockEdge();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, 6'd2, 5'd7, 1, (i == 10), 32'h3f000000, 5'd0, 0);
            nChecks++; if (gnt_o !== 1'b0) begin nErrors++; $display("[TB] FAIL div_block_%0d: got %0b want 0", i, gnt_o); end
            clockEdge();
        end
        nChecks++; if (result_valid_o !== 1'b1 || result_waddr_o !== 5'd3) begin nErrors++; $display("[TB] FAIL div_result: got v=%0b w=%0d want v=1 w=3", result_valid_o, result_waddr_o); end
        applyStimulus(1, 6'd2, 5'd7, 1, 0, 32'd0, 5'd0, 0);
        nChecks++; if (gnt_o !== 1'b1) begin nErrors++; $display("[TB] FAIL mul_gnt: got %0b want 1", gnt_o); end
        clockEdge();
        applyStimulus(0, 6'd0, 5'd0, 0, 1, 32'h41000000, 5'd0, 0);
        clockEdge();
        nChecks++; if (result_valid_o !== 1'b1 || result_waddr_o !== 5'd7) begin nErrors++; $display("[TB] FAIL mul_result: got v=%0b w=%0d want v=1 w=7", result_valid_o, result_waddr_o); end
    endtask

    task automatic test_fill_wrap();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 6'd0, 5'(i), 1, 0, 32'd0, 5'd0, 0);
            clockEdge();
        end
        applyStimulus(1, 6'd0, 5'd9, 1, 0, 32'd0, 5'd0, 0);
        nChecks++; if (gnt_o !== 1'b0 || apu_req_o !== 1'b0) begin nErrors++; $display("[TB] FAIL full_gnt: got gnt=%0b req=%0b want 0 0", gnt_o, apu_req_o); end
        clockEdge();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 6'd0, 5'd0, 0, 1, 32'(i * 16), 5'd0, 0);
            clockEdge();
            nChecks++; if (result_waddr_o !== 5'(i) || result_data_o !== 32'(i * 16)) begin nErrors++; $display("[TB] FAIL fill_order_%0d: got w=%0d d=%0h want w=%0d", i, result_waddr_o, result_data_o, i); end
        end
        applyStimulus(1, 6'd1, 5'd10, 1, 0, 32'd0, 5'd0, 0);
        clockEdge();
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1, 6'd1, 5'(10 + i), 1, 1, 32'd0, 5'd0, 0);
            nChecks++; if (gnt_o !== 1'b1) begin nErrors++; $display("[TB] FAIL wrap_gnt_%0d: got %0b want 1", i, gnt_o); end
            clockEdge();
            nChecks++; if (result_waddr_o !== 5'(9 + i)) begin nErrors++; $display("[TB] FAIL wrap_order_%0d: got %0d want %0d", i, result_waddr_o, 9 + i); end
        end
        applyStimulus(0, 6'd0, 5'd0, 0, 1, 32'd0, 5'd0, 0);
        clockEdge();
        nChecks++; if (result_waddr_o !== 5'd17 || busy_o !== 1'b1) begin nErrors++; $display("[TB] FAIL wrap_last: got w=%0d busy=%0b want w=17 busy=1", result_waddr_o, busy_o); end
        idle();
        clockEdge();
        nChecks++; if (busy_o !== 1'b0) begin nErrors++; $display("[TB] FAIL wrap_idle: got busy=%0b want 0", busy_o); end
    endtask

    task automatic test_fflags();
        applyStimulus(0, 6'd0, 5'd0, 0, 0, 32'd0, 5'd0, 1);
        clockEdge();
        applyStimulus(1, 6'd0, 5'd1, 1, 1, 32'd1, 5'b00001, 0);
        clockEdge();
        applyStimulus(1, 6'd0, 5'd2, 1, 1, 32'd2, 5'b10000, 0);
        clockEdge();
        nChecks++; if (fflags_o !== 5'b10001) begin nErrors++; $display("[TB] FAIL fflags_acc: got %5b want 10001", fflags_o); end
        nChecks++; if (result_flags_o !== 5'b10000) begin nErrors++; $display("[TB] FAIL fflags_op: got %5b want 10000", result_flags_o); end
        applyStimulus(1, 6'd0, 5'd3, 1, 1, 32'd3, 5'b00100, 1);
        clockEdge();
        nChecks++; if (fflags_o !== 5'b00100) begin nErrors++; $display("[TB] FAIL fflags_clr: got %5b want 00100", fflags_o); end
    endtask

    task automatic test_spurious();
        applyStimulus(0, 6'd0, 5'd0, 1, 1, 32'hdeadbeef, 5'b11111, 0);
        clockEdge();
        nChecks++; if (result_valid_o !== 1'b0 || err_o !== 1'b1) begin nErrors++; $display("[TB] FAIL spurious: got v=%0b err=%0b want v=0 err=1", result_valid_o, err_o); end
        nChecks++; if (fflags_o !== 5'b00100) begin nErrors++; $display("[TB] FAIL spurious_ff: got %5b want 00100", fflags_o); end
        repeat (3) begin idle(); clockEdge(); end
        nChecks++; if (err_o !== 1'b1) begin nErrors++; $display("[TB] FAIL err_sticky: got %0b want 1", err_o); end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 6'd0, 5'(20 + i), 1, 0, 32'd0, 5'd0, 0);
            clockEdge();
        end
        applyStimulus(0, 6'd0, 5'd0, 0, 1, 32'd0, 5'd0, 0);
        clockEdge();
        idle();
        rst_ni = 0;
        #1;
        nChecks++; if ({busy_o, result_valid_o, err_o, fflags_o} !== 8'd0) begin nErrors++; $display("[TB] FAIL midop_reset: got busy=%0b v=%0b err=%0b ff=%5b want all 0", busy_o, result_valid_o, err_o, fflags_o); end
        modelClear();
        @(posedge clk_i);
        #1;
        rst_ni = 1;
        applyStimulus(1, 6'd0, 5'd9, 1, 1, 32'h12345678, 5'd0, 0);
        nChecks++; if (gnt_o !== 1'b1) begin nErrors++; $display("[TB] FAIL post_reset_gnt: got %0b want 1", gnt_o); end
        clockEdge();
        nChecks++; if (result_waddr_o !== 5'd9 || result_data_o !== 32'h12345678) begin nErrors++; $display("[TB] FAIL post_reset_res: got w=%0d d=%0h want w=9", result_waddr_o, result_data_o); end
        idle();
        clockEdge();
        nChecks++; if (busy_o !== 1'b0) begin nErrors++; $display("[TB] FAIL post_reset_busy: got %0b want 0 (stale entries)", busy_o); end
    endtask

    task automatic test_random();
        logic rv;
        for (int i = 0; i < 400; i++) begin
            rv = (modelQ.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            applyStimulus($urandom_range(0, 1) == 1, 6'($urandom), 5'($urandom),
                          $urandom_range(0, 3) != 0, rv, $urandom, 5'($urandom),
                          $urandom_range(0, 9) == 0);
            nChecks++; if (gnt_o !== expGnt || apu_req_o !== expReq) begin nErrors++; $display("[TB] FAIL rnd_gnt_%0d: got gnt=%0b req=%0b want %0b %0b", i, gnt_o, apu_req_o, expGnt, expReq); end
            nChecks++; if (busy_o !== expBusy) begin nErrors++; $display("[TB] FAIL rnd_busy_%0d: got %0b want %0b", i, busy_o, expBusy); end
            nChecks++; if (apu_operands_o !== operands_i || apu_op_o !== op_i || apu_flags_o !== flags_i) begin nErrors++; $display("[TB] FAIL rnd_pass_%0d: got op=%0h flags=%0h want op=%0h flags=%0h", i, apu_op_o, apu_flags_o, op_i, flags_i); end
            clockEdge();
            nChecks++; if (result_valid_o !== modelRv || result_waddr_o !== modelWaddr || result_data_o !== modelData || result_flags_o !== modelFlags) begin nErrors++; $display("[TB] FAIL rnd_result_%0d: got v=%0b w=%0d d=%0h f=%5b want v=%0b w=%0d d=%0h f=%5b", i, result_valid_o, result_waddr_o, result_data_o, result_flags_o, modelRv, modelWaddr, modelData, modelFlags); end
            nChecks++; if (fflags_o !== modelFf || err_o !== modelErr) begin nErrors++; $display("[TB] FAIL rnd_status_%0d: got ff=%5b err=%0b want ff=%5b err=%0b", i, fflags_o, err_o, modelFf, modelErr); end
        end
    endtask

    initial begin
        $display("[TB] starting rv32imf_fp_issue_tracker bench");
        test_reset();
        test_comb_fpu();
        test_div_order();
        test_fill_wrap();
        test_fflags();
        test_spurious();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
